// File: rtl/multiplier_16bit.sv
`default_nettype none
// ============================================================================
//  Module      : multiplier_16bit
//  Description : Registered unsigned 10-bit x 6-bit multiplier. A structural
//                shift-and-add array (six partial-product rows reduced by
//                ripple-carry full-adder rows) feeds a single output register,
//                giving a 16-bit product one cycle after the operands.
//  Revision    : 1.0  - initial release
// ============================================================================
module multiplier_16bit (
   input  logic        clk,
   input  logic        reset,
   input  logic [9:0]  in1,
   input  logic [5:0]  in2,
   output logic [15:0] out
);

   // Number of partial-product rows (one per multiplier bit) and row width.
   localparam int c_ROWS  = 6;
   localparam int c_WIDTH = 10;

   // ------------------------------------------------------------------------
   // Partial products: row j is the multiplicand gated by multiplier bit j.
   // Its 2^j weight is implicit in where the row enters the reduction.
   // ------------------------------------------------------------------------
   logic [c_ROWS-1:0][c_WIDTH-1:0] w_pp;

   generate
      for (genvar j = 0; j < c_ROWS; j++) begin : g_pp
         assign w_pp[j] = in1 & {c_WIDTH{in2[j]}};
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Row 0 passes straight through. Its LSB is already final (product bit 0);
   // the remaining nine bits, shifted down, are the running sum that row 1
   // is added to. The vacated MSB is zero because there is no carry yet.
   // ------------------------------------------------------------------------
   logic [c_WIDTH-1:0] w_acc0;
   logic               w_bit0;

   assign w_bit0 = w_pp[0][0];
   assign w_acc0 = {1'b0, w_pp[0][c_WIDTH-1:1]};

   // ------------------------------------------------------------------------
   // Reduction rows 1..5. Each row adds partial product j to the running sum
   // with a 10-bit ripple-carry chain of full adders. The adder's carry-out
   // becomes the MSB of the next running sum, and the LSB of this row's sum
   // is retired as product bit j. All signals are kept local to each row and
   // each bit cell so that every net has a single, non-overlapping driver.
   // ------------------------------------------------------------------------
   generate
      for (genvar r = 1; r < c_ROWS; r++) begin : g_row
         logic [c_WIDTH-1:0] w_acc_in;   // running sum entering this row
         logic [c_WIDTH-1:0] w_sum;      // ripple-adder sum bits
         logic               w_cout;     // ripple-adder carry-out

         // Running sum input: from row 0 for the first adder row, otherwise
         // the previous row's carry-out concatenated with its shifted sum.
         if (r == 1) begin : g_first
            assign w_acc_in = w_acc0;
         end else begin : g_next
            assign w_acc_in = {g_row[r-1].w_cout, g_row[r-1].w_sum[c_WIDTH-1:1]};
         end

         for (genvar b = 0; b < c_WIDTH; b++) begin : g_bit
            logic w_a;
            logic w_b;
            logic w_ci;
            logic w_s;
            logic w_co;

            assign w_a = w_acc_in[b];
            assign w_b = w_pp[r][b];

            // Carry-in: zero into the LSB cell, otherwise the neighbour's
            // carry-out rippling up from below.
            if (b == 0) begin : g_lsb
               assign w_ci = 1'b0;
            end else begin : g_chain
               assign w_ci = g_bit[b-1].w_co;
            end

            // Full-adder cell.
            assign w_s  = w_a ^ w_b ^ w_ci;
            assign w_co = (w_a & w_b) | (w_ci & (w_a ^ w_b));

            assign w_sum[b] = w_s;
         end

         assign w_cout = g_bit[c_WIDTH-1].w_co;
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Product assembly: the low six bits are the bits retired by row 0 and by
   // each adder row; the upper ten bits are what remains of the last running
   // sum (final carry-out on top). 10 + 6 = 16 bits, so nothing overflows.
   // ------------------------------------------------------------------------
   logic [15:0] w_product;

   assign w_product = {g_row[5].w_cout,
                       g_row[5].w_sum[c_WIDTH-1:1],
                       g_row[5].w_sum[0],
                       g_row[4].w_sum[0],
                       g_row[3].w_sum[0],
                       g_row[2].w_sum[0],
                       g_row[1].w_sum[0],
                       w_bit0};

   // ------------------------------------------------------------------------
   // Output register: the only state in the block. Reset forces zero and
   // dominates whatever operands are present at the same edge.
   // ------------------------------------------------------------------------
   logic [15:0] r_out;

   // Capture the array result every cycle; synchronous reset clears it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out <= 16'h0000;
      end else begin
         r_out <= w_product;
      end
   end

   assign out = r_out;

endmodule
`default_nettype wire

// File: tb/tb_multiplier_16bit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multiplier_16bit
//  Description : Self-checking bench for multiplier_16bit. Directed corner
//                cases, randomized back-to-back traffic with a mid-stream
//                reset, and a full sweep of every operand pair, all compared
//                against an arithmetic reference one cycle after the edge.
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_multiplier_16bit;

   logic        clk;
   logic        reset;
   logic [9:0]  in1;
   logic [5:0]  in2;
   logic [15:0] out;

   int n_checks = 0;
   int n_fail   = 0;

   multiplier_16bit u_dut (
      .clk   (clk),
      .reset (reset),
      .in1   (in1),
      .in2   (in2),
      .out   (out)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: the registered value after an edge is zero under reset,
   // otherwise the plain integer product of the operands seen at that edge.
   function automatic logic [15:0] ref_mul(input logic [9:0] a,
                                           input logic [5:0] b,
                                           input logic       r);
      int unsigned p;
      p = r ? 0 : int'(a) * int'(b);
      return p[15:0];
   endfunction

   task automatic check(input string tag, input logic [15:0] obs,
                        input logic [15:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one operand pair (and reset) away from the clock edge, let the
   // rising edge capture it, then compare the registered output.
   task automatic step(input logic [9:0] a, input logic [5:0] b,
                       input logic r, input logic [15:0] exp,
                       input string tag);
      @(negedge clk);
      in1   = a;
      in2   = b;
      reset = r;
      @(posedge clk);
      #1;
      check(tag, out, exp);
   endtask

   initial begin
      logic [9:0] a;
      logic [5:0] b;
      logic       r;

      in1   = '0;
      in2   = '0;
      reset = 1'b1;

      // Reset held for two cycles with maximum operands present.
      step(10'h3ff, 6'h3f, 1'b1, 16'h0000, "reset_hold0");
      step(10'h3ff, 6'h3f, 1'b1, 16'h0000, "reset_hold1");
      step(10'h3ff, 6'h3f, 1'b0, 16'hFBC1, "reset_release");

      // Output must hold between edges.
      @(negedge clk);
      check("hold_between_edges", out, 16'hFBC1);

      // Corner and maximum.
      step(10'h000, 6'h00, 1'b0, 16'h0000, "zero_zero");
      step(10'h3ff, 6'h3f, 1'b0, 16'hFBC1, "max_max");

      // Mixed operands interleaved with zero pairs.
      step(10'h03f, 6'h1f, 1'b0, 16'h07A1, "mix_03f_1f");
      step(10'h000, 6'h00, 1'b0, 16'h0000, "mix_zero0");
      step(10'h3ff, 6'h30, 1'b0, 16'hBFD0, "mix_3ff_30");
      step(10'h000, 6'h00, 1'b0, 16'h0000, "mix_zero1");
      step(10'h3de, 6'h3f, 1'b0, 16'hF3A2, "mix_3de_3f");
      step(10'h000, 6'h00, 1'b0, 16'h0000, "mix_zero2");
      step(10'h33f, 6'h3f, 1'b0, 16'hCC81, "mix_33f_3f");
      step(10'h000, 6'h00, 1'b0, 16'h0000, "mix_zero3");
      step(10'h3ef, 6'h3f, 1'b0, 16'hF7D1, "mix_3ef_3f");
      step(10'h000, 6'h00, 1'b0, 16'h0000, "mix_zero4");

      // Identity and zero operands.
      step(10'h2a5, 6'h01, 1'b0, 16'h02A5, "identity");
      step(10'h3ff, 6'h00, 1'b0, 16'h0000, "in2_zero");
      step(10'h000, 6'h3f, 1'b0, 16'h0000, "in1_zero");

      // Randomized back-to-back traffic with a one-cycle reset pulse in the
      // middle; the pulse must zero exactly that cycle's output.
      for (int k = 0; k < 200; k++) begin
         a = 10'($urandom);
         b = 6'($urandom);
         r = (k == 100);
         step(a, b, r, ref_mul(a, b, r), r ? "rand_reset_pulse" : "rand_b2b");
      end

      // Exhaustive sweep of every operand pair, one per cycle.
      for (int i = 0; i < 1024; i++) begin
         for (int j = 0; j < 64; j++) begin
            a = 10'(i);
            b = 6'(j);
            step(a, b, 1'b0, ref_mul(a, b, 1'b0), "sweep");
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
